// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed CPU requests into single word-bus transactions
// with lane masking, load extension and misaligned/unmapped/timeout error reporting.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// ACCESS | one cycle of strobes, mem_done ignored (may be stale)
// WAIT   | holding the bus until mem_done or the timeout terminal count
// RESP   | one-cycle response pulse
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_BITS   = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_wen,
    output logic        mem_ren,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done,
    input  logic        mem_active
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state, state_nx;

    logic                    write_q;
    logic [1:0]              size_q;
    logic                    unsigned_q;
    logic [1:0]              offset_q;
    logic [TIMEOUT_BITS-1:0] tcnt;
    logic                    timeout_tc;
    logic                    misaligned;
    logic [3:0]              wmask_nx;
    logic [31:0]             wdata_nx;
    logic [31:0]             shifted;
    logic [31:0]             load_ext;

    assign timeout_tc = (tcnt == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1));

    assign misaligned = (req_size == 2'b11)
                      | ((req_size == 2'b01) & req_addr[0])
                      | ((req_size == 2'b10) & (|req_addr[1:0]));

    always_comb begin
        wmask_nx = 4'b1111;
        wdata_nx = req_wdata;
        case (req_size)
            2'b00: begin
                wmask_nx = 4'b0001 << req_addr[1:0];
                wdata_nx = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wmask_nx = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_nx = {2{req_wdata[15:0]}};
            end
            default: begin
                wmask_nx = 4'b1111;
                wdata_nx = req_wdata;
            end
        endcase
    end

    // Load lane selection and extension from the latched offset/size.
    always_comb begin
        shifted  = mem_rdata >> {offset_q, 3'b000};
        load_ext = shifted;
        case (size_q)
            2'b00:   load_ext = unsigned_q ? {24'h0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = unsigned_q ? {16'h0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_wen    = 1'b0;
        mem_ren    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nx = misaligned ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_ren  = ~write_q & mem_active;
                mem_wen  = write_q & mem_active;
                state_nx = mem_active ? WAIT : RESP;
            end
            WAIT: begin
                mem_ren = ~write_q;
                if (mem_done || timeout_tc) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            offset_q   <= 2'b00;
            tcnt       <= '0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wmask  <= 4'h0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        offset_q   <= req_addr[1:0];
                        resp_err   <= misaligned;
                        resp_rdata <= 32'h0;
                        // Bus-facing registers keep their old value on a misaligned request.
                        if (!misaligned) begin
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wmask <= wmask_nx;
                            mem_wdata <= wdata_nx;
                        end
                    end
                end
                ACCESS: begin
                    tcnt <= '0;
                    if (!mem_active) begin
                        resp_err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_done) begin
                        resp_err <= 1'b0;
                        if (!write_q) begin
                            resp_rdata <= load_ext;
                        end
                    end else if (timeout_tc) begin
                        resp_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TIMEOUT_BITS'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table, hand-written timeout/reset sequences and
// random traffic against a byte-array reference model of a small memory device.
module tb_load_store_unit;

    localparam int TC = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_active;

    int checks = 0;
    int failures = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
        .mem_done(mem_done), .mem_active(mem_active)
    );

    always #5 clk = ~clk;

    // Device: 16 words decoded at 0xFxxxxxxx. Mode 0 = 1-cycle device, 1 = never done,
    // 2 = done only while the read-strobe run length equals done_at.
    int          dev_mode = 0;
    int          done_at = 0;
    logic        dev_clr = 1'b1;
    logic [31:0] dmem [16];
    logic [31:0] rdata_q = 32'h0;
    logic        done_q = 1'b0;
    int          ren_run = 0;

    assign mem_active = (mem_addr[31:28] == 4'hF);
    assign mem_rdata  = rdata_q;
    assign mem_done   = (dev_mode == 0) ? done_q :
                        (dev_mode == 2) ? (ren_run == done_at) : 1'b0;

    always @(posedge clk) begin
        if (dev_clr) begin
            for (int i = 0; i < 16; i++) dmem[i] <= 32'h0;
        end else if (mem_wen && mem_active) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) dmem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        rdata_q <= dmem[mem_addr[5:2]];
        done_q  <= (mem_wen | mem_ren) & mem_active;
        ren_run <= mem_ren ? ren_run + 1 : 0;
    end

    logic [7:0] ref_mem [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: rules applied to a byte array, little-endian assembly of loads.
    task automatic model(input bit w, input logic [1:0] sz, input bit u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic e, output logic [31:0] rd, output int lat);
        int n;
        int base;
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e = 1'b0; rd = 32'h0; lat = 3;
        if (sz == 2'd3 || (a % n) != 0) begin
            e = 1'b1; lat = 1;
        end else if (a[31:28] != 4'hF) begin
            e = 1'b1; lat = 2;
        end else begin
            base = int'(a[5:0]);
            if (w) begin
                for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
                if (!u && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
                rd = v;
            end
        end
    endtask

    task automatic run_access(input bit w, input logic [1:0] sz, input bit u,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic e, output logic [31:0] rd, output int lat,
                              output int wen_n, output int ren_n,
                              output logic [3:0] wm, output logic [31:0] wdo);
        int guard;
        e = 1'b0; rd = 32'h0; lat = -1; wen_n = 0; ren_n = 0; wm = 4'h0; wdo = 32'h0;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL req_ready_wait actual=0 required=1");
            return;
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= TC + 10; k++) begin
            @(negedge clk);
            if (mem_wen) begin
                wen_n++; wm = mem_wmask; wdo = mem_wdata;
            end
            if (mem_ren) ren_n++;
            if (resp_valid) begin
                lat = k; e = resp_err; rd = resp_rdata;
                break;
            end
        end
        if (lat < 0) begin
            checks++; failures++;
            $display("FAIL resp_timeout actual=none required=resp_valid");
        end
    endtask

    typedef struct {
        bit          w;
        logic [1:0]  sz;
        bit          u;
        logic [31:0] a;
        logic [31:0] wd;
        logic        e;
        logic [31:0] rd;
        int          lat;
        int          wen;
        int          ren;
        logic [3:0]  wm;
        logic [31:0] wdo;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e, me;
        logic [31:0] rd, mrd, wdo;
        logic [3:0]  wm;
        int          lat, mlat, wen_n, ren_n, seen;
        bit          w, u;
        logic [1:0]  sz;
        logic [31:0] a, wd;

        tbl[0]  = '{1, 2'd2, 0, 32'hF0000010, 32'hDEADBEEF, 0, 32'h0,        3, 1, 0, 4'hF, 32'hDEADBEEF};
        tbl[1]  = '{0, 2'd2, 0, 32'hF0000010, 32'h0,        0, 32'hDEADBEEF, 3, 0, 2, 4'h0, 32'h0};
        tbl[2]  = '{1, 2'd0, 0, 32'hF0000013, 32'h00000080, 0, 32'h0,        3, 1, 0, 4'h8, 32'h80808080};
        tbl[3]  = '{0, 2'd0, 0, 32'hF0000013, 32'h0,        0, 32'hFFFFFF80, 3, 0, 2, 4'h0, 32'h0};
        tbl[4]  = '{0, 2'd0, 1, 32'hF0000013, 32'h0,        0, 32'h00000080, 3, 0, 2, 4'h0, 32'h0};
        tbl[5]  = '{0, 2'd2, 0, 32'hF0000010, 32'h0,        0, 32'h80ADBEEF, 3, 0, 2, 4'h0, 32'h0};
        tbl[6]  = '{1, 2'd1, 0, 32'hF0000006, 32'h00001234, 0, 32'h0,        3, 1, 0, 4'hC, 32'h12341234};
        tbl[7]  = '{0, 2'd1, 0, 32'hF0000006, 32'h0,        0, 32'h00001234, 3, 0, 2, 4'h0, 32'h0};
        tbl[8]  = '{0, 2'd1, 0, 32'hF0000005, 32'h0,        1, 32'h0,        1, 0, 0, 4'h0, 32'h0};
        tbl[9]  = '{0, 2'd2, 0, 32'h00001000, 32'h0,        1, 32'h0,        2, 0, 0, 4'h0, 32'h0};
        tbl[10] = '{0, 2'd3, 0, 32'hF0000000, 32'h0,        1, 32'h0,        1, 0, 0, 4'h0, 32'h0};
        tbl[11] = '{1, 2'd1, 0, 32'hF0000000, 32'hABCD8001, 0, 32'h0,        3, 1, 0, 4'h3, 32'h80018001};
        tbl[12] = '{0, 2'd1, 0, 32'hF0000000, 32'h0,        0, 32'hFFFF8001, 3, 0, 2, 4'h0, 32'h0};
        tbl[13] = '{0, 2'd0, 1, 32'hF0000001, 32'h0,        0, 32'h00000080, 3, 0, 2, 4'h0, 32'h0};
        tbl[14] = '{0, 2'd2, 0, 32'hF0000004, 32'h0,        0, 32'h12340000, 3, 0, 2, 4'h0, 32'h0};
        tbl[15] = '{1, 2'd0, 0, 32'hF0000012, 32'h0000005A, 0, 32'h0,        3, 1, 0, 4'h4, 32'h5A5A5A5A};
        tbl[16] = '{0, 2'd1, 1, 32'hF0000012, 32'h0,        0, 32'h0000805A, 3, 0, 2, 4'h0, 32'h0};
        tbl[17] = '{1, 2'd2, 0, 32'hF0000002, 32'h11111111, 1, 32'h0,        1, 0, 0, 4'h0, 32'h0};

        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h0;

        rst = 1'b1; dev_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_strobes", {30'h0, mem_wen, mem_ren}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wmask", 32'(mem_wmask), 32'h0);
        rst = 1'b0; dev_clr = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_access(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd,
                       e, rd, lat, wen_n, ren_n, wm, wdo);
            model(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, me, mrd, mlat);
            check($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].e));
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            check($sformatf("tbl%0d_wen_cycles", i), 32'(wen_n), 32'(tbl[i].wen));
            check($sformatf("tbl%0d_ren_cycles", i), 32'(ren_n), 32'(tbl[i].ren));
            if (tbl[i].w && !tbl[i].e) begin
                check($sformatf("tbl%0d_wmask", i), 32'(wm), 32'(tbl[i].wm));
                check($sformatf("tbl%0d_wdata", i), wdo, tbl[i].wdo);
            end
        end

        // Device never answers: TC WAIT cycles, then error.
        dev_mode = 1;
        run_access(0, 2'd2, 0, 32'hF0000000, 32'h0, e, rd, lat, wen_n, ren_n, wm, wdo);
        check("timeout_err", 32'(e), 32'd1);
        check("timeout_latency", 32'(lat), 32'(TC + 2));
        check("timeout_ren_cycles", 32'(ren_n), 32'(TC + 1));
        check("timeout_rdata", rd, 32'h0);

        // Store against a silent device: single write strobe, then timeout.
        run_access(1, 2'd2, 0, 32'hF0000008, 32'h55AA55AA, e, rd, lat, wen_n, ren_n, wm, wdo);
        model(1, 2'd2, 0, 32'hF0000008, 32'h55AA55AA, me, mrd, mlat);
        check("timeout_store_err", 32'(e), 32'd1);
        check("timeout_store_wen_cycles", 32'(wen_n), 32'd1);

        // done on the last WAIT cycle beats the terminal count.
        dev_mode = 2; done_at = TC;
        run_access(0, 2'd2, 0, 32'hF0000000, 32'h0, e, rd, lat, wen_n, ren_n, wm, wdo);
        check("late_done_err", 32'(e), 32'd0);
        check("late_done_latency", 32'(lat), 32'(TC + 2));
        check("late_done_rdata", rd, 32'h00008001);

        // done one cycle after the last WAIT cycle is too late.
        done_at = TC + 1;
        run_access(0, 2'd2, 0, 32'hF0000000, 32'h0, e, rd, lat, wen_n, ren_n, wm, wdo);
        check("too_late_done_err", 32'(e), 32'd1);
        check("too_late_done_latency", 32'(lat), 32'(TC + 2));

        // done only during ACCESS is stale and must be ignored.
        done_at = 0;
        run_access(0, 2'd2, 0, 32'hF0000000, 32'h0, e, rd, lat, wen_n, ren_n, wm, wdo);
        check("stale_done_err", 32'(e), 32'd1);
        check("stale_done_latency", 32'(lat), 32'(TC + 2));

        // Reset pulse while in WAIT drops the access.
        dev_mode = 1;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'hF0000010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_in_wait_ren", 32'(mem_ren), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("post_rst_strobes", {30'h0, mem_wen, mem_ren}, 32'h0);
        check("post_rst_mem_addr", mem_addr, 32'h0);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("post_rst_no_resp", 32'(seen), 32'd0);
        dev_mode = 0;
        run_access(0, 2'd2, 0, 32'hF0000010, 32'h0, e, rd, lat, wen_n, ren_n, wm, wdo);
        model(0, 2'd2, 0, 32'hF0000010, 32'h0, me, mrd, mlat);
        check("after_rst_err", 32'(e), 32'(me));
        check("after_rst_rdata", rd, mrd);
        check("after_rst_latency", 32'(lat), 32'(mlat));

        // Random traffic against the reference model.
        for (int it = 0; it < 300; it++) begin
            w  = bit'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            u  = bit'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 32'h00002000 | 32'($urandom_range(0, 63));
            else a = 32'hF0000000 | 32'($urandom_range(0, 63));
            wd = $urandom;
            run_access(w, sz, u, a, wd, e, rd, lat, wen_n, ren_n, wm, wdo);
            model(w, sz, u, a, wd, me, mrd, mlat);
            check($sformatf("rnd%0d_err", it), 32'(e), 32'(me));
            check($sformatf("rnd%0d_rdata", it), rd, mrd);
            check($sformatf("rnd%0d_latency", it), 32'(lat), 32'(mlat));
            check($sformatf("rnd%0d_wen_cycles", it), 32'(wen_n), (w && !me) ? 32'd1 : 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
